// File: rtl/fft_result_if.sv
// Port bundle for fft_result: FFT output stream in, peak status out, and the
// result read-back handshake.
`timescale 1ns/1ps
interface fft_result_if #(
    parameter int AW = 10
);
    logic               fft_oen;
    logic               fft_osop;
    logic               fft_oeop;
    logic signed [15:0] fft_odat_i;
    logic signed [15:0] fft_odat_q;
    logic               res_busy;
    logic               peak_vld;
    logic [AW-1:0]      peak_idx;
    logic [31:0]        peak_pwr;
    logic               rd_en;
    logic [AW-1:0]      rd_addr;
    logic               rd_vld;
    logic [31:0]        rd_data;
    logic               rd_ack;
    logic               frm_err;

    modport master (
        output fft_oen, fft_osop, fft_oeop, fft_odat_i, fft_odat_q,
        output rd_en, rd_addr, rd_ack,
        input  res_busy, peak_vld, peak_idx, peak_pwr, rd_vld, rd_data, frm_err
    );

    modport slave (
        input  fft_oen, fft_osop, fft_oeop, fft_odat_i, fft_odat_q,
        input  rd_en, rd_addr, rd_ack,
        output res_busy, peak_vld, peak_idx, peak_pwr, rd_vld, rd_data, frm_err
    );
endinterface

// File: rtl/fft_result.sv
// Captures one FFT output frame, stores per-bin power |I|^2+|Q|^2 in a RAM,
// tracks the peak bin and holds the result until the consumer acknowledges it.
`timescale 1ns/1ps
module fft_result #(
    parameter int NPT = 1024,
    parameter int AW  = 10
) (
    input  logic         clk,
    input  logic         rst,
    fft_result_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        DRAIN,
        DONE
    } state_t;

    localparam logic [AW-1:0] LAST = AW'(NPT - 1);

    state_t        state;
    state_t        state_next;
    logic [AW-1:0] cnt;
    logic [AW-1:0] cnt_next;
    logic [1:0]    dcnt;
    logic [1:0]    dcnt_next;
    logic          ack_q;
    logic          frm_err_next;
    logic          accept;
    logic          start;

    logic          s1_vld;
    logic [15:0]   s1_i;
    logic [15:0]   s1_q;
    logic [AW-1:0] s1_bin;
    logic          s2_vld;
    logic [30:0]   s2_i2;
    logic [30:0]   s2_q2;
    logic [AW-1:0] s2_bin;

    logic [15:0]   abs_i;
    logic [15:0]   abs_q;
    logic [30:0]   sq_i;
    logic [30:0]   sq_q;
    logic [31:0]   sum;

    logic [31:0]   ram [NPT];
    logic [31:0]   peak_pwr;
    logic [AW-1:0] peak_idx;
    logic          rd_vld;
    logic [31:0]   rd_data;
    logic          frm_err;

    always_comb begin
        state_next   = state;
        cnt_next     = cnt;
        dcnt_next    = dcnt;
        frm_err_next = 1'b0;
        accept       = 1'b0;
        start        = 1'b0;
        case (state)
            IDLE: begin
                if (bus.fft_oen && bus.fft_osop) begin
                    start      = 1'b1;
                    accept     = 1'b1;
                    cnt_next   = AW'(1);
                    state_next = COLLECT;
                end
            end
            COLLECT: begin
                if (bus.fft_oen) begin
                    accept = 1'b1;
                    // A fresh SOP restarts the frame in place rather than dropping it.
                    if (bus.fft_osop) begin
                        start        = 1'b1;
                        frm_err_next = 1'b1;
                        cnt_next     = AW'(1);
                    end else if (cnt == LAST) begin
                        cnt_next = '0;
                        if (bus.fft_oeop) begin
                            dcnt_next  = '0;
                            state_next = DRAIN;
                        end else begin
                            frm_err_next = 1'b1;
                            state_next   = IDLE;
                        end
                    end else if (bus.fft_oeop) begin
                        frm_err_next = 1'b1;
                        cnt_next     = '0;
                        state_next   = IDLE;
                    end else begin
                        cnt_next = cnt + AW'(1);
                    end
                end
            end
            DRAIN: begin
                if (dcnt == 2'd3) begin
                    state_next = DONE;
                end else begin
                    dcnt_next = dcnt + 2'd1;
                end
            end
            DONE: begin
                if (bus.fft_oen) begin
                    frm_err_next = 1'b1;
                end
                if (ack_q) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // The acknowledge is registered so the result drops one edge after RDACK is seen.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            dcnt    <= '0;
            ack_q   <= 1'b0;
            frm_err <= 1'b0;
        end else begin
            state   <= state_next;
            cnt     <= cnt_next;
            dcnt    <= dcnt_next;
            ack_q   <= (state == DONE) && bus.rd_ack;
            frm_err <= frm_err_next;
        end
    end

    // Squaring the magnitude keeps (-32768)^2 = 2^30 exact in 31 unsigned bits.
    assign abs_i = s1_i[15] ? (~s1_i + 16'd1) : s1_i;
    assign abs_q = s1_q[15] ? (~s1_q + 16'd1) : s1_q;
    assign sq_i  = 31'(abs_i) * 31'(abs_i);
    assign sq_q  = 31'(abs_q) * 31'(abs_q);
    assign sum   = {1'b0, s2_i2} + {1'b0, s2_q2};

    // A frame start squashes older in-flight samples so they cannot touch the new peak.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_vld   <= 1'b0;
            s1_i     <= '0;
            s1_q     <= '0;
            s1_bin   <= '0;
            s2_vld   <= 1'b0;
            s2_i2    <= '0;
            s2_q2    <= '0;
            s2_bin   <= '0;
            peak_pwr <= '0;
            peak_idx <= '0;
        end else begin
            s1_vld <= accept;
            if (accept) begin
                s1_i   <= bus.fft_odat_i;
                s1_q   <= bus.fft_odat_q;
                s1_bin <= start ? '0 : cnt;
            end
            s2_vld <= s1_vld && !start;
            s2_i2  <= sq_i;
            s2_q2  <= sq_q;
            s2_bin <= s1_bin;
            if (start) begin
                peak_pwr <= '0;
                peak_idx <= '0;
            end else if (s2_vld && (sum > peak_pwr)) begin
                peak_pwr <= sum;
                peak_idx <= s2_bin;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (s2_vld && !start) begin
            ram[s2_bin] <= sum;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_vld  <= 1'b0;
            rd_data <= '0;
        end else begin
            rd_vld <= bus.rd_en && (state == DONE);
            if (bus.rd_en && (state == DONE)) begin
                rd_data <= ram[bus.rd_addr];
            end
        end
    end

    assign bus.res_busy = (state != IDLE);
    assign bus.peak_vld = (state == DONE);
    assign bus.peak_idx = peak_idx;
    assign bus.peak_pwr = peak_pwr;
    assign bus.rd_vld   = rd_vld;
    assign bus.rd_data  = rd_data;
    assign bus.frm_err  = frm_err;
endmodule

// File: tb/tb_fft_result.sv
// Randomized self-checking bench for fft_result against a frame-level power/peak model.
`timescale 1ns/1ps
module tb_fft_result;
    localparam int NPT = 1024;
    localparam int AW  = 10;

    logic   clk = 1'b0;
    logic   rst;
    int     tests = 0;
    int     fails = 0;
    int     err_seen = 0;
    int     fi [NPT];
    int     fq [NPT];
    longint exp_pwr [NPT];
    longint exp_peak;
    int     exp_idx;
    longint last_rd = 0;

    fft_result_if #(.AW(AW)) bus ();

    fft_result #(.NPT(NPT), .AW(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #3_000_000;
        $display("[TB] FAIL watchdog: simulation still running, expected finish");
        $fatal(1, "[TB] timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (bus.frm_err) err_seen++;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, want);
        end
    endtask

    // Frame-level reference: power per bin, first maximum wins, empty peak is (0,0).
    task automatic run_model();
        exp_peak = 0;
        exp_idx  = 0;
        for (int b = 0; b < NPT; b++) begin
            exp_pwr[b] = longint'(fi[b]) * fi[b] + longint'(fq[b]) * fq[b];
            if (exp_pwr[b] > exp_peak) begin
                exp_peak = exp_pwr[b];
                exp_idx  = b;
            end
        end
    endtask

    task automatic fill_frame(input int amp);
        for (int b = 0; b < NPT; b++) begin
            if (amp == 0) begin
                fi[b] = 0;
                fq[b] = 0;
            end else begin
                fi[b] = int'($urandom_range(0, 2 * amp)) - amp;
                fq[b] = int'($urandom_range(0, 2 * amp)) - amp;
            end
        end
    endtask

    task automatic applyStimulus(input int nsamp, input int eop_idx, input bit gaps);
        for (int k = 0; k < nsamp; k++) begin
            if (gaps) begin
                int g;
                g = int'($urandom_range(0, 2));
                repeat (g) tick();
            end
            bus.fft_oen    = 1'b1;
            bus.fft_osop   = (k == 0);
            bus.fft_oeop   = (k == eop_idx);
            bus.fft_odat_i = 16'(fi[k]);
            bus.fft_odat_q = 16'(fq[k]);
            tick();
            bus.fft_oen  = 1'b0;
            bus.fft_osop = 1'b0;
            bus.fft_oeop = 1'b0;
        end
    endtask

    // Called just after the edge that sampled EOP of a good frame.
    task automatic check_frame(input string tag);
        checkOutput({tag, " busy@eop"}, bus.res_busy, 1);
        checkOutput({tag, " peakvld@eop"}, bus.peak_vld, 0);
        tick();
        tick();
        tick();
        checkOutput({tag, " peakvld@eop+3"}, bus.peak_vld, 0);
        tick();
        checkOutput({tag, " peakvld@eop+4"}, bus.peak_vld, 1);
        checkOutput({tag, " peakidx"}, bus.peak_idx, exp_idx);
        checkOutput({tag, " peakpwr"}, bus.peak_pwr, exp_peak);
    endtask

    task automatic do_read(input string tag, input int addr);
        bus.rd_en   = 1'b1;
        bus.rd_addr = AW'(addr);
        tick();
        bus.rd_en = 1'b0;
        checkOutput({tag, " rdvld"}, bus.rd_vld, 1);
        checkOutput({tag, " rddata"}, bus.rd_data, exp_pwr[addr]);
        last_rd = exp_pwr[addr];
    endtask

    task automatic finish_result(input string tag);
        bus.rd_ack = 1'b1;
        tick();
        bus.rd_ack = 1'b0;
        checkOutput({tag, " busy@ack"}, bus.res_busy, 1);
        tick();
        checkOutput({tag, " busy after ack"}, bus.res_busy, 0);
        checkOutput({tag, " peakvld after ack"}, bus.peak_vld, 0);
    endtask

    task automatic check_all_zero(input string tag);
        checkOutput({tag, " busy"}, bus.res_busy, 0);
        checkOutput({tag, " peakvld"}, bus.peak_vld, 0);
        checkOutput({tag, " peakidx"}, bus.peak_idx, 0);
        checkOutput({tag, " peakpwr"}, bus.peak_pwr, 0);
        checkOutput({tag, " rdvld"}, bus.rd_vld, 0);
        checkOutput({tag, " rddata"}, bus.rd_data, 0);
        checkOutput({tag, " frmerr"}, bus.frm_err, 0);
    endtask

    initial begin
        int e0;
        int seen;
        rst            = 1'b1;
        bus.fft_oen    = 1'b0;
        bus.fft_osop   = 1'b0;
        bus.fft_oeop   = 1'b0;
        bus.fft_odat_i = '0;
        bus.fft_odat_q = '0;
        bus.rd_en      = 1'b0;
        bus.rd_addr    = '0;
        bus.rd_ack     = 1'b0;
        repeat (3) tick();
        check_all_zero("reset");
        rst = 1'b0;
        tick();

        // Single peak at bin 37.
        fill_frame(0);
        fi[37] = 1000;
        fq[37] = -2000;
        run_model();
        e0 = err_seen;
        applyStimulus(NPT, NPT - 1, 1'b0);
        check_frame("single");
        checkOutput("single pwr const", bus.peak_pwr, 5000000);
        do_read("single bin37", 37);
        do_read("single bin36", 36);
        checkOutput("single no frmerr", err_seen - e0, 0);
        finish_result("single");

        // Extreme values, tie between bins 5 and 900, gapped input.
        fill_frame(1000);
        fi[5] = -32768; fq[5] = -32768;
        fi[900] = -32768; fq[900] = -32768;
        run_model();
        applyStimulus(NPT, NPT - 1, 1'b1);
        check_frame("extreme");
        checkOutput("extreme pwr const", bus.peak_pwr, 64'd2147483648);
        checkOutput("extreme idx const", bus.peak_idx, 5);
        do_read("extreme bin900", 900);
        do_read("extreme rand", int'($urandom_range(0, NPT - 1)));
        finish_result("extreme");

        // Early EOP on sample 500 discards the frame.
        fill_frame(500);
        e0 = err_seen;
        applyStimulus(501, 500, 1'b0);
        checkOutput("early frmerr", bus.frm_err, 1);
        checkOutput("early busy", bus.res_busy, 0);
        seen = 0;
        repeat (8) begin
            tick();
            if (bus.peak_vld) seen++;
        end
        checkOutput("early peakvld never", seen, 0);
        checkOutput("early frmerr count", err_seen - e0, 1);
        fill_frame(1000);
        fi[1000] = 20000;
        fq[1000] = -15000;
        run_model();
        applyStimulus(NPT, NPT - 1, 1'b1);
        check_frame("after early");
        checkOutput("after early idx const", bus.peak_idx, 1000);
        finish_result("after early");

        // SOP mid-frame restarts; earlier large peak must not survive.
        fill_frame(0);
        fi[10] = 1000;
        e0 = err_seen;
        applyStimulus(300, -1, 1'b0);
        fill_frame(0);
        fi[20] = 20;
        run_model();
        applyStimulus(NPT, NPT - 1, 1'b0);
        check_frame("restart");
        checkOutput("restart frmerr count", err_seen - e0, 1);
        checkOutput("restart pwr const", bus.peak_pwr, 400);
        finish_result("restart");

        // Reads before DONE are ignored, overruns flag errors, read+ack together.
        bus.rd_en   = 1'b1;
        bus.rd_addr = AW'($urandom_range(0, NPT - 1));
        tick();
        bus.rd_en = 1'b0;
        checkOutput("idle read rdvld", bus.rd_vld, 0);
        checkOutput("idle read rddata held", bus.rd_data, last_rd);
        fill_frame(25000);
        run_model();
        applyStimulus(NPT, NPT - 1, 1'b0);
        bus.rd_en   = 1'b1;
        bus.rd_addr = AW'(exp_idx);
        tick();
        bus.rd_en = 1'b0;
        checkOutput("drain read rdvld", bus.rd_vld, 0);
        tick();
        tick();
        tick();
        checkOutput("hs peakvld", bus.peak_vld, 1);
        e0 = err_seen;
        repeat (3) begin
            bus.fft_oen = 1'b1;
            tick();
            bus.fft_oen = 1'b0;
            tick();
        end
        checkOutput("overrun frmerr count", err_seen - e0, 3);
        checkOutput("overrun peakidx", bus.peak_idx, exp_idx);
        checkOutput("overrun peakpwr", bus.peak_pwr, exp_peak);
        bus.rd_en   = 1'b1;
        bus.rd_addr = AW'(exp_idx);
        bus.rd_ack  = 1'b1;
        tick();
        bus.rd_en  = 1'b0;
        bus.rd_ack = 1'b0;
        last_rd = exp_pwr[exp_idx];
        checkOutput("ack read rdvld", bus.rd_vld, 1);
        checkOutput("ack read rddata", bus.rd_data, exp_pwr[exp_idx]);
        checkOutput("ack busy@ack", bus.res_busy, 1);
        tick();
        checkOutput("ack busy after", bus.res_busy, 0);
        checkOutput("ack peakvld after", bus.peak_vld, 0);

        // Asynchronous reset in the middle of a frame.
        fill_frame(20000);
        applyStimulus(600, -1, 1'b0);
        checkOutput("pre-reset busy", bus.res_busy, 1);
        #2;
        rst = 1'b1;
        #1;
        check_all_zero("async reset");
        tick();
        rst = 1'b0;
        last_rd = 0;
        e0 = err_seen;
        seen = 0;
        for (int k = 0; k < 20; k++) begin
            bus.fft_oen    = 1'b1;
            bus.fft_oeop   = (k == 10);
            bus.fft_odat_i = 16'($urandom_range(0, 65535));
            bus.fft_odat_q = 16'($urandom_range(0, 65535));
            tick();
            if (bus.res_busy) seen++;
        end
        bus.fft_oen  = 1'b0;
        bus.fft_oeop = 1'b0;
        checkOutput("no-sop busy", seen, 0);
        checkOutput("no-sop frmerr", err_seen - e0, 0);

        // Randomized good frames.
        for (int n = 0; n < 3; n++) begin
            fill_frame(int'($urandom_range(1, 32767)));
            if (n == 1) begin
                fi[$urandom_range(0, NPT - 1)] = -32768;
            end
            run_model();
            applyStimulus(NPT, NPT - 1, n[0]);
            check_frame("random");
            do_read("random peak", exp_idx);
            do_read("random any", int'($urandom_range(0, NPT - 1)));
            finish_result("random");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
